dcache_shared_port_arbiter: RTL and testbench

//  Shares one D$ request port (wt_cache_subsystem port 3) between the store unit and the accelerator dispatcher.

---
 rtl/dcache_shared_port_arbiter.sv | 103 ++++++++++
 tb/tb_dcache_shared_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_shared_port_arbiter.sv
// dcache_shared_port_arbiter: shares one D$ request port between the store unit and the accelerator
package dcache_shared_port_arbiter_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic [1:0]  data_id;
    logic        data_we;
    logic        data_req;
  } dcache_req_i_t;
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [1:0]  data_rid;
    logic [31:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_shared_port_arbiter
  import dcache_shared_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxStall = 16,
  parameter int unsigned NumRd    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  dcache_req_i_t                st_req_i,
  output dcache_req_o_t                st_rsp_o,
  input  dcache_req_i_t                acc_req_i,
  output dcache_req_o_t                acc_rsp_o,
  output dcache_req_i_t                cache_req_o,
  input  dcache_req_o_t                cache_rsp_i,
  output logic                         starve_boost_o,
  output logic [$clog2(NumRd+1)-1:0]   rd_outstanding_o
);
  localparam int CW = $clog2(NumRd + 1);
  localparam int PW = $clog2(NumRd);
  localparam int SW = MaxStall > 0 ? $clog2(MaxStall + 1) : 1;
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e            state;
  logic             lock_acc, own_acc, has_own, boost, full, fwd, gnt, push, pop, head;
  logic [SW-1:0]    starve_cnt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [NumRd-1:0] owner_q;
  dcache_req_i_t    own_req;
  always_comb begin
    boost = state == UNLOCKED && st_req_i.data_req && acc_req_i.data_req &&
            MaxStall != 0 && starve_cnt == SW'(MaxStall);
    has_own = state == LOCKED || st_req_i.data_req || acc_req_i.data_req;
    own_acc = state == LOCKED ? lock_acc : (acc_req_i.data_req && !st_req_i.data_req) || boost;
    own_req = !has_own ? '0 : own_acc ? acc_req_i : st_req_i;
    full = count == CW'(NumRd);
    // a read is held back while every owner slot is taken, even if one frees this cycle
    fwd = own_req.data_req && (own_req.data_we || !full);
    cache_req_o = own_req;
    cache_req_o.data_req = fwd;
    gnt = fwd && cache_rsp_i.data_gnt;
    push = gnt && !own_req.data_we;
    pop = cache_rsp_i.data_rvalid && count != '0;
    head = owner_q[rd_ptr];
    st_rsp_o = pop && !head ? cache_rsp_i : '0;
    acc_rsp_o = pop && head ? cache_rsp_i : '0;
    st_rsp_o.data_gnt = gnt && !own_acc;
    acc_rsp_o.data_gnt = gnt && own_acc;
    starve_boost_o = boost;
    rd_outstanding_o = count;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= UNLOCKED;
      lock_acc <= 1'b0;
      starve_cnt <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      owner_q <= '0;
    end else begin
      if (flush_i || gnt || !own_req.data_req) state <= UNLOCKED;
      else if (fwd) begin
        state <= LOCKED;
        lock_acc <= own_acc;
      end
      starve_cnt <= flush_i || (gnt && own_acc) ? '0 :
                    gnt && acc_req_i.data_req && starve_cnt != SW'(MaxStall) ? starve_cnt + 1'b1 : starve_cnt;
      if (push) begin
        owner_q[wr_ptr] <= own_acc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) cache_rsp_i.data_rvalid |-> count != '0);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) !(st_rsp_o.data_gnt && acc_rsp_o.data_gnt));
  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state == LOCKED && own_req.data_req |-> own_req == $past(own_req));
`endif
endmodule

// File: tb/tb_dcache_shared_port_arbiter.sv
// tb_dcache_shared_port_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_dcache_shared_port_arbiter;
  import dcache_shared_port_arbiter_pkg::*;
  localparam int MAX_STALL = 16;
  localparam int NUM_RD = 4;
  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  dcache_req_i_t st_req, acc_req, cache_req_o;
  dcache_req_o_t st_rsp_o, acc_rsp_o, cache_rsp;
  logic starve_boost_o;
  logic [2:0] rd_outstanding_o;
  int checks = 0, errors = 0;
  bit m_locked, m_lock_acc;
  int m_cnt, e_own;
  bit m_q[$];
  dcache_req_i_t e_req;
  dcache_req_o_t e_st, e_acc;
  bit e_gnt, e_boost;

  dcache_shared_port_arbiter #(.MaxStall(MAX_STALL), .NumRd(NUM_RD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .st_req_i(st_req), .st_rsp_o(st_rsp_o), .acc_req_i(acc_req), .acc_rsp_o(acc_rsp_o),
    .cache_req_o(cache_req_o), .cache_rsp_i(cache_rsp),
    .starve_boost_o(starve_boost_o), .rd_outstanding_o(rd_outstanding_o));

  always #5 clk_i = ~clk_i;

  function automatic dcache_req_i_t mk(logic [31:0] a, logic we, logic [1:0] id);
    mk = '0;
    mk.address = a;
    mk.data_wdata = a ^ 32'hA5A5_0000;
    mk.data_be = 4'hF;
    mk.data_size = 2'd2;
    mk.data_id = id;
    mk.data_we = we;
    mk.data_req = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    st_req = '0; acc_req = '0; cache_rsp = '0; flush_i = 0; rst_ni = 0;
    repeat (2) tick();
    rst_ni = 1;
    m_locked = 0; m_lock_acc = 0; m_cnt = 0; m_q.delete();
  endtask

  // Model: who owns the port follows the arbitration rules directly; reads are tracked as an ordered list of owners
  task automatic model_eval();
    bit sw = st_req.data_req, aw = acc_req.data_req;
    bit starved = MAX_STALL > 0 && m_cnt >= MAX_STALL;
    if (m_locked) e_own = m_lock_acc ? 1 : 0;
    else if (sw && aw) e_own = starved ? 1 : 0;
    else if (sw) e_own = 0;
    else if (aw) e_own = 1;
    else e_own = -1;
    e_boost = !m_locked && sw && aw && starved;
    e_req = e_own == 0 ? st_req : e_own == 1 ? acc_req : '0;
    if (!e_req.data_we && m_q.size() == NUM_RD) e_req.data_req = 0;
    e_gnt = e_req.data_req && cache_rsp.data_gnt;
    e_st = '0; e_acc = '0;
    if (cache_rsp.data_rvalid && m_q.size() > 0) begin
      if (m_q[0]) e_acc = cache_rsp; else e_st = cache_rsp;
    end
    e_st.data_gnt = e_gnt && e_own == 0;
    e_acc.data_gnt = e_gnt && e_own == 1;
  endtask

  task automatic model_update();
    bit raw = e_own == 1 ? acc_req.data_req : e_own == 0 ? st_req.data_req : 0;
    if (flush_i || (e_gnt && e_own == 1)) m_cnt = 0;
    else if (e_gnt && acc_req.data_req && m_cnt < MAX_STALL) m_cnt++;
    if (cache_rsp.data_rvalid && m_q.size() > 0) void'(m_q.pop_front());
    if (e_gnt && !e_req.data_we) m_q.push_back(e_own == 1);
    if (!m_locked) m_lock_acc = e_own == 1;
    m_locked = !flush_i && !e_gnt && (m_locked ? raw : e_req.data_req);
  endtask

  task automatic test_reset();
    st_req = '0; acc_req = '0; cache_rsp = '0; flush_i = 0; rst_ni = 0;
    @(negedge clk_i);
    checks++; if (cache_req_o !== '0) begin errors++; $display("FAIL reset_cache_req got %h want 0", cache_req_o); end
    checks++; if (st_rsp_o !== '0 || acc_rsp_o !== '0) begin errors++; $display("FAIL reset_rsp got %h/%h want 0", st_rsp_o, acc_rsp_o); end
    checks++; if (rd_outstanding_o !== 3'd0 || starve_boost_o !== 1'b0) begin errors++; $display("FAIL reset_status got %0d/%b want 0/0", rd_outstanding_o, starve_boost_o); end
    tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic test_starvation();
    int win, st_wins;
    bit b;
    for (int r = 0; r < 2; r++) begin
      st_req = mk(32'h100 + r, 1, 0); acc_req = mk(32'h200 + r, 1, 1);
      cache_rsp = '0; cache_rsp.data_gnt = 1;
      win = 0; b = 0; st_wins = 0;
      for (int i = 1; i <= 40 && win == 0; i++) begin
        @(negedge clk_i);
        if (acc_rsp_o.data_gnt) begin win = i; b = starve_boost_o; end
        if (st_rsp_o.data_gnt) st_wins++;
        tick();
      end
      checks++; if (win != 17) begin errors++; $display("FAIL starve_win_cycle r%0d got %0d want 17", r, win); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL starve_boost r%0d got %b want 1", r, b); end
      checks++; if (st_wins != 16) begin errors++; $display("FAIL starve_st_wins r%0d got %0d want 16", r, st_wins); end
      acc_req = '0;
      @(negedge clk_i);
      checks++; if (cache_req_o !== st_req) begin errors++; $display("FAIL starve_st_only got %h want %h", cache_req_o, st_req); end
      tick();
    end
    st_req = '0; cache_rsp = '0;
  endtask

  task automatic test_lock_hold();
    st_req = '0; acc_req = mk(32'h300, 1, 1); cache_rsp = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) st_req = mk(32'h400, 1, 0);
      if (c == 5) acc_req = '0;
      cache_rsp.data_gnt = c >= 4;
      @(negedge clk_i);
      if (c <= 4) begin
        checks++; if (cache_req_o !== acc_req || st_rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL lock_hold c%0d got %h want %h", c, cache_req_o, acc_req); end
      end
      if (c == 4) begin
        checks++; if (acc_rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL lock_acc_gnt got %b want 1", acc_rsp_o.data_gnt); end
      end
      if (c == 5) begin
        checks++; if (st_rsp_o.data_gnt !== 1'b1 || cache_req_o !== st_req) begin errors++; $display("FAIL lock_st_after got %b/%h want 1/%h", st_rsp_o.data_gnt, cache_req_o, st_req); end
      end
      tick();
    end
    st_req = '0; cache_rsp = '0;
  endtask

  task automatic test_read_routing();
    logic [31:0] d [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    cache_rsp = '0; cache_rsp.data_gnt = 1;
    acc_req = mk(32'hA00, 0, 1); tick();
    acc_req = mk(32'hB00, 0, 2); tick();
    acc_req = '0; st_req = mk(32'hC00, 0, 3); tick();
    st_req = '0; cache_rsp = '0;
    @(negedge clk_i);
    checks++; if (rd_outstanding_o !== 3'd3) begin errors++; $display("FAIL rd_out_3 got %0d want 3", rd_outstanding_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      cache_rsp = '0; cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = d[k]; cache_rsp.data_rid = 2'(k);
      @(negedge clk_i);
      checks++;
      if (k < 2 ? (acc_rsp_o.data_rvalid !== 1'b1 || acc_rsp_o.data_rdata !== d[k] || st_rsp_o.data_rvalid !== 1'b0)
                : (st_rsp_o.data_rvalid !== 1'b1 || st_rsp_o.data_rdata !== d[k] || acc_rsp_o.data_rvalid !== 1'b0)) begin
        errors++; $display("FAIL rd_route k%0d got acc %b/%h st %b/%h want %h", k, acc_rsp_o.data_rvalid, acc_rsp_o.data_rdata, st_rsp_o.data_rvalid, st_rsp_o.data_rdata, d[k]);
      end
      checks++; if (rd_outstanding_o !== 3'(3 - k)) begin errors++; $display("FAIL rd_out_k%0d got %0d want %0d", k, rd_outstanding_o, 3 - k); end
      tick();
    end
    cache_rsp = '0;
    @(negedge clk_i);
    checks++; if (rd_outstanding_o !== 3'd0) begin errors++; $display("FAIL rd_out_0 got %0d want 0", rd_outstanding_o); end
    tick();
  endtask

  task automatic test_fifo_full();
    cache_rsp = '0; cache_rsp.data_gnt = 1;
    for (int i = 0; i < 4; i++) begin acc_req = mk(32'h500 + i, 0, 2'(i)); tick(); end
    acc_req = mk(32'h600, 0, 0);
    for (int c = 0; c < 3; c++) begin
      cache_rsp.data_rvalid = c == 2; cache_rsp.data_rdata = 32'h5000;
      @(negedge clk_i);
      checks++; if (cache_req_o.data_req !== 1'b0 || acc_rsp_o.data_gnt !== 1'b0) begin errors++; $display("FAIL full_gate c%0d got %b/%b want 0/0", c, cache_req_o.data_req, acc_rsp_o.data_gnt); end
      tick();
    end
    cache_rsp.data_rvalid = 0;
    @(negedge clk_i);
    checks++; if (cache_req_o.data_req !== 1'b1 || acc_rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL full_release got %b/%b want 1/1", cache_req_o.data_req, acc_rsp_o.data_gnt); end
    tick();
    acc_req = '0; cache_rsp = '0;
    @(negedge clk_i);
    checks++; if (rd_outstanding_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", rd_outstanding_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'h5100 + k;
      @(negedge clk_i);
      checks++; if (acc_rsp_o.data_rvalid !== 1'b1 || acc_rsp_o.data_rdata !== 32'h5100 + k) begin errors++; $display("FAIL full_drain k%0d got %b/%h", k, acc_rsp_o.data_rvalid, acc_rsp_o.data_rdata); end
    end
    tick();
    cache_rsp = '0;
  endtask

  task automatic test_flush();
    int win;
    bit b;
    cache_rsp = '0; cache_rsp.data_gnt = 1;
    acc_req = mk(32'h700, 0, 0); tick();
    acc_req = mk(32'h704, 0, 1); tick();
    st_req = mk(32'h800, 1, 0); acc_req = mk(32'h900, 1, 1);
    repeat (5) tick();
    st_req = '0; cache_rsp.data_gnt = 0; tick();
    st_req = mk(32'h804, 1, 0); flush_i = 1;
    @(negedge clk_i);
    checks++; if (cache_req_o !== acc_req) begin errors++; $display("FAIL flush_locked got %h want %h", cache_req_o, acc_req); end
    tick();
    flush_i = 0; cache_rsp.data_gnt = 1;
    @(negedge clk_i);
    checks++; if (st_rsp_o.data_gnt !== 1'b1) begin errors++; $display("FAIL flush_unlock got %b want 1", st_rsp_o.data_gnt); end
    tick();
    win = 0; b = 0;
    for (int i = 1; i <= 40 && win == 0; i++) begin
      @(negedge clk_i);
      if (acc_rsp_o.data_gnt) begin win = i; b = starve_boost_o; end
      tick();
    end
    checks++; if (win != 16 || b !== 1'b1) begin errors++; $display("FAIL flush_cnt_clear got %0d/%b want 16/1", win, b); end
    st_req = '0; acc_req = '0; cache_rsp = '0;
    for (int k = 0; k < 2; k++) begin
      cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'h7000 + k;
      @(negedge clk_i);
      checks++; if (acc_rsp_o.data_rvalid !== 1'b1 || acc_rsp_o.data_rdata !== 32'h7000 + k || st_rsp_o.data_rvalid !== 1'b0) begin errors++; $display("FAIL flush_drain k%0d got %b/%h", k, acc_rsp_o.data_rvalid, acc_rsp_o.data_rdata); end
      tick();
    end
    cache_rsp = '0;
  endtask

  task automatic test_reset_midlock();
    cache_rsp = '0; cache_rsp.data_gnt = 1;
    acc_req = mk(32'hD00, 0, 0); tick();
    acc_req = mk(32'hD04, 0, 1); tick();
    acc_req = mk(32'hD08, 1, 2); cache_rsp.data_gnt = 0; tick();
    #2 rst_ni = 0;
    #1;
    checks++; if (rd_outstanding_o !== 3'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", rd_outstanding_o); end
    acc_req = '0; cache_rsp = '0;
    #1;
    checks++; if (cache_req_o !== '0 || st_rsp_o !== '0 || acc_rsp_o !== '0 || starve_boost_o !== 1'b0) begin errors++; $display("FAIL rst_outputs got %h/%h/%h", cache_req_o, st_rsp_o, acc_rsp_o); end
    tick();
    rst_ni = 1;
    st_req = mk(32'hE00, 1, 0); acc_req = mk(32'hE04, 1, 1);
    @(negedge clk_i);
    checks++; if (cache_req_o !== st_req || rd_outstanding_o !== 3'd0) begin errors++; $display("FAIL rst_st_priority got %h/%0d want %h/0", cache_req_o, rd_outstanding_o, st_req); end
    tick();
    st_req = '0; acc_req = '0;
  endtask

  task automatic test_random();
    dcache_req_i_t st_p, acc_p;
    bit st_v = 0, acc_v = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!st_v && $urandom_range(0, 2) != 0) begin st_v = 1; st_p = mk($urandom, 1'($urandom_range(0, 1)), 2'($urandom)); end
      if (!acc_v && $urandom_range(0, 2) != 0) begin acc_v = 1; acc_p = mk($urandom, 1'($urandom_range(0, 1)), 2'($urandom)); end
      st_req = st_v ? st_p : '0;
      acc_req = acc_v ? acc_p : '0;
      cache_rsp = '0;
      cache_rsp.data_gnt = 1'($urandom_range(0, 1));
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = $urandom; cache_rsp.data_rid = 2'($urandom);
      end
      flush_i = $urandom_range(0, 19) == 0;
      @(negedge clk_i);
      model_eval();
      checks++; if (cache_req_o !== e_req) begin errors++; $display("FAIL rnd_cache_req n%0d got %h want %h", n, cache_req_o, e_req); end
      checks++; if (st_rsp_o !== e_st) begin errors++; $display("FAIL rnd_st_rsp n%0d got %h want %h", n, st_rsp_o, e_st); end
      checks++; if (acc_rsp_o !== e_acc) begin errors++; $display("FAIL rnd_acc_rsp n%0d got %h want %h", n, acc_rsp_o, e_acc); end
      checks++; if (starve_boost_o !== e_boost) begin errors++; $display("FAIL rnd_boost n%0d got %b want %b", n, starve_boost_o, e_boost); end
      checks++; if (rd_outstanding_o !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_outstanding n%0d got %0d want %0d", n, rd_outstanding_o, m_q.size()); end
      if (e_st.data_gnt) st_v = 0;
      if (e_acc.data_gnt) acc_v = 0;
      model_update();
      tick();
    end
    st_req = '0; acc_req = '0; cache_rsp = '0; flush_i = 0;
  endtask

  initial begin
    st_req = '0; acc_req = '0; cache_rsp = '0;
    test_reset();
    test_starvation();
    test_lock_hold();
    test_read_routing();
    test_fifo_full();
    test_flush();
    test_reset_midlock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
